move_input_handler: RTL
=======================

Name: move_input_handler

Overview:
Parametrised player-move front end for the switch/button board games. Captures a one-hot cell selection from the switches on a debounced button press and checks it against the board occupancy it owns. Valid moves are committed and handed to the renderer through a draw request/ack handshake; the block then advances the turn across N_PLAYERS and detects game end. It sits between the board I/O pins and the game/draw controller.

Parameters:
CELLS, 9, number of board cells = switch width (2..32)
N_PLAYERS, 2, players in rotation (2..8); PW = max(1,$clog2(N_PLAYERS))
DRAW_TIMEOUT, 1023, max cycles waiting for drawing to rise before forcing completion (>=1)
DEB_CYCLES, 15, stable-high cycles required by debounce (used only with INPUT_DEBOUNCE_EN)

Ports:
clock  input  1  system clock
reset  input  1  reset, synchronous, active-high
sw  input  CELLS  raw switch bank, one-hot cell select
button  input  1  raw async move-submit button, active-high
new_game  input  1  synchronous level; restarts from GAMEOVER
drawing  input  1  renderer busy flag (acts as ack)
win  input  1  win flag from game logic, sampled in ADVANCE
meta_sw  output  CELLS  registered move selection
cell_idx  output  $clog2(CELLS)  binary index of last committed cell
player  output  PW  player whose turn it is
occupied  output  CELLS  per-cell occupancy bitmap
draw_req  output  1  render request for committed move
holding  output  1  high whenever state != READ
move_reject  output  1  1-cycle pulse on invalid move
gameover  output  1  game finished
tie  output  1  board full without win (valid with gameover)
winner  output  PW  winning player (valid when gameover & !tie)

Behaviour:
- Reset: state READ; all outputs 0; owner table cleared; timeout counter 0.
- button passes through a 2-flop synchroniser then rising-edge detect; press pulse occurs 2 cycles after button first sampled high. Presses outside READ are dropped, with no queuing.
- READ: meta_sw <= sw every cycle. On press: meta_sw <= sw, go to CHECK. meta_sw is frozen in all other states.
- CHECK (1 cycle): valid = meta_sw is exactly one-hot AND (meta_sw & occupied)==0.
  - Invalid (zero, multi-hot, or occupied): move_reject=1 for one cycle, back to READ; player unchanged.
  - Valid: occupied |= meta_sw; owner[idx] <= player; cell_idx <= idx; draw_req <= 1; go to DRAW_ACK.
- DRAW_ACK: draw_req held high; counter increments each cycle.
  - drawing==1: draw_req <= 0, go to DRAW_BUSY.
  - Counter reaches DRAW_TIMEOUT first: draw_req <= 0, go to ADVANCE, skipping DRAW_BUSY.
  - Counter clears on entry to DRAW_ACK.
- DRAW_BUSY: wait for drawing==0, then go to ADVANCE.
- ADVANCE (1 cycle):
  - win=1: gameover<=1, winner<=player, tie<=0, go to GAMEOVER. Win takes priority over full board.
  - Else occupied all ones: gameover<=1, tie<=1, go to GAMEOVER.
  - Else player <= (player==N_PLAYERS-1) ? 0 : player+1, go to READ.
- GAMEOVER: hold all outputs. new_game=1 clears occupied, owner table, player, gameover, tie, winner and cell_idx, then goes to READ on the next cycle.
- reset at any time, including mid-handshake, returns to READ with draw_req dropped immediately; renderer state is not the block's concern.
- holding is combinational from state; all other outputs are registered.

Optional Feature:
INPUT_DEBOUNCE_EN:
- Defined: press requires the synchronised button to stay high for DEB_CYCLES consecutive cycles; press pulse occurs on the cycle the count is reached. Any low sample resets the count. A new press needs button low for at least 1 synchronised cycle first.
- Undefined: plain synchronised rising-edge detect; DEB_CYCLES unused.

Test Plan:
1. CELLS=9, reset, sw=9'b000010000, press; drawing high 3 cycles after draw_req, low 5 cycles later -> occupied=0x010, cell_idx=4, player changes 0->1 in the ADVANCE cycle, holding low afterwards.
2. Cell 4 already occupied; press with sw=0x010, then with sw=0x003, then with sw=0 -> three move_reject pulses, occupied and player unchanged, no draw_req.
3. Valid move, drawing never rises, DRAW_TIMEOUT=8 -> draw_req high exactly 8 cycles, then ADVANCE, player advances.
4. Fill all 9 cells alternately with win=0 -> final ADVANCE sets gameover=1, tie=1; presses ignored; new_game -> occupied=0, player=0, state READ.
5. N_PLAYERS=3, win=1 on player 2's move -> gameover=1, winner=2, tie=0; reset asserted during a DRAW_ACK state -> all outputs 0 next cycle.
6. With INPUT_DEBOUNCE_EN, DEB_CYCLES=4: 3-cycle button glitch -> no press; 6-cycle hold -> exactly one press.

Source files
------------

// File: rtl/move_input_handler.sv
// -----------------------------------------------------------------------------
// move_input_handler
//
// Player-move front end for the switch/button board games. A submit press
// captures a one-hot cell selection from the switch bank. The selection is
// checked against the occupancy bitmap that this block owns. Valid moves are
// committed and offered to the renderer over a draw request/ack handshake.
// The block then rotates the turn across N_PLAYERS and detects the end of
// the game (win or full board).
//
// Optional build macro:
//   INPUT_DEBOUNCE_EN - when defined, a press needs the synchronised button
//                       to stay high for DEB_CYCLES consecutive cycles.
//                       When undefined, a press is a plain synchronised
//                       rising edge and DEB_CYCLES has no effect.
//
// Draw handshake (renderer side):
//   draw_req rises on the cycle after a move is committed. It stays high
//   until the renderer raises drawing, or until DRAW_TIMEOUT cycles have
//   elapsed. If drawing was seen, the block then waits for drawing to fall
//   before advancing the turn. A renderer that never answers cannot stall
//   the game.
//
// Ports:
//   clock, reset  system clock; synchronous active-high reset
//   sw            raw switch bank, one-hot cell select
//   button        raw asynchronous move-submit button (active high)
//   new_game      level; restarts a finished game
//   drawing       renderer busy flag, acts as the draw acknowledge
//   win           win flag from game logic, sampled while advancing
//   meta_sw       registered move selection
//   cell_idx      binary index of the last committed cell
//   player        player whose turn it is
//   occupied      per-cell occupancy bitmap
//   draw_req      render request for the committed move
//   holding       high whenever the block is not reading a new move
//   move_reject   one-cycle pulse for an invalid move
//   gameover      game finished
//   tie           board full without a win (qualified by gameover)
//   winner        winning player (qualified by gameover & !tie)
//   dbg_state     current FSM state, for observation
//   dbg_owner     owner table, PW bits per cell, cell 0 in the low bits
// -----------------------------------------------------------------------------
module move_input_handler #(
   parameter  int CELLS        = 9,
   parameter  int N_PLAYERS    = 2,
   parameter  int DRAW_TIMEOUT = 1023,
   parameter  int DEB_CYCLES   = 15,
   localparam int PW           = (N_PLAYERS > 2) ? $clog2(N_PLAYERS) : 1,
   localparam int IW           = $clog2(CELLS)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [CELLS-1:0]      sw,
   input  logic                  button,
   input  logic                  new_game,
   input  logic                  drawing,
   input  logic                  win,
   output logic [CELLS-1:0]      meta_sw,
   output logic [IW-1:0]         cell_idx,
   output logic [PW-1:0]         player,
   output logic [CELLS-1:0]      occupied,
   output logic                  draw_req,
   output logic                  holding,
   output logic                  move_reject,
   output logic                  gameover,
   output logic                  tie,
   output logic [PW-1:0]         winner,
   output logic [2:0]            dbg_state,
   output logic [CELLS*PW-1:0]   dbg_owner
);

   localparam int TW = $clog2(DRAW_TIMEOUT + 1);

   typedef enum logic [2:0] {
      ST_READ      = 3'd0,
      ST_CHECK     = 3'd1,
      ST_DRAW_ACK  = 3'd2,
      ST_DRAW_BUSY = 3'd3,
      ST_ADVANCE   = 3'd4,
      ST_GAMEOVER  = 3'd5
   } state_t;

   state_t                    r_state;
   state_t                    w_state_next;

   logic [1:0]                r_btn_sync;
   logic                      w_press;

   logic [CELLS-1:0]          r_meta_sw;
   logic [IW-1:0]             r_cell_idx;
   logic [PW-1:0]             r_player;
   logic [CELLS-1:0]          r_occupied;
   logic                      r_draw_req;
   logic                      r_move_reject;
   logic                      r_gameover;
   logic                      r_tie;
   logic [PW-1:0]             r_winner;
   logic [CELLS-1:0][PW-1:0]  r_owner;
   logic [TW-1:0]             r_draw_cnt;

   logic                      w_onehot;
   logic                      w_valid;
   logic [IW-1:0]             w_idx;
   logic [TW-1:0]             w_cnt_next;
   logic                      w_timeout;
   logic                      w_board_full;
   logic [PW-1:0]             w_player_next;

   // ---------------------------------------------------------------------------
   // Button synchroniser and press detection
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         r_btn_sync <= '0;
      end else begin
         r_btn_sync <= {r_btn_sync[0], button};
      end
   end

`ifdef INPUT_DEBOUNCE_EN
   localparam int DW = $clog2(DEB_CYCLES + 1);
   logic [DW-1:0] r_deb_cnt;

   // The counter saturates at DEB_CYCLES. A long hold therefore fires only once,
   // and only a low sample re-arms the detector.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_deb_cnt <= '0;
      end else if (!r_btn_sync[1]) begin
         r_deb_cnt <= '0;
      end else if (r_deb_cnt != DW'(DEB_CYCLES)) begin
         r_deb_cnt <= r_deb_cnt + DW'(1);
      end
   end

   assign w_press = r_btn_sync[1] && (r_deb_cnt == DW'(DEB_CYCLES - 1));
`else
   logic r_btn_last;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_btn_last <= 1'b0;
      end else begin
         r_btn_last <= r_btn_sync[1];
      end
   end

   assign w_press = r_btn_sync[1] && !r_btn_last;

   // DEB_CYCLES only shapes the debounced build. It is referenced here so that
   // it stays elaborated in the plain build.
   if (DEB_CYCLES < 1) begin : g_deb_cycles_unused
   end
`endif

   // ---------------------------------------------------------------------------
   // Move validation helpers
   // ---------------------------------------------------------------------------
   // x & (x-1) clears the lowest set bit. It is zero only for zero or one-hot x.
   assign w_onehot     = (r_meta_sw != '0) &&
                         ((r_meta_sw & (r_meta_sw - CELLS'(1))) == '0);
   assign w_valid      = w_onehot && ((r_meta_sw & r_occupied) == '0);
   assign w_cnt_next   = r_draw_cnt + TW'(1);
   assign w_timeout    = (w_cnt_next == TW'(DRAW_TIMEOUT));
   assign w_board_full = &r_occupied;
   assign w_player_next = (r_player == PW'(N_PLAYERS - 1)) ? '0 : r_player + PW'(1);

   always_comb begin
      w_idx = '0;
      for (int i = 0; i < CELLS; i++) begin
         if (r_meta_sw[i]) begin
            w_idx = IW'(i);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= ST_READ;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_READ:      if (w_press) w_state_next = ST_CHECK;
         ST_CHECK:     w_state_next = w_valid ? ST_DRAW_ACK : ST_READ;
         // An acknowledge wins over a timeout that expires in the same cycle.
         ST_DRAW_ACK: begin
            if (drawing) begin
               w_state_next = ST_DRAW_BUSY;
            end else if (w_timeout) begin
               w_state_next = ST_ADVANCE;
            end
         end
         ST_DRAW_BUSY: if (!drawing) w_state_next = ST_ADVANCE;
         ST_ADVANCE:   w_state_next = (win || w_board_full) ? ST_GAMEOVER : ST_READ;
         ST_GAMEOVER:  if (new_game) w_state_next = ST_READ;
         default:      w_state_next = ST_READ;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         r_meta_sw     <= '0;
         r_cell_idx    <= '0;
         r_player      <= '0;
         r_occupied    <= '0;
         r_draw_req    <= 1'b0;
         r_move_reject <= 1'b0;
         r_gameover    <= 1'b0;
         r_tie         <= 1'b0;
         r_winner      <= '0;
         r_owner       <= '0;
         r_draw_cnt    <= '0;
      end else begin
         r_move_reject <= 1'b0;
         case (r_state)
            ST_READ: r_meta_sw <= sw;
            ST_CHECK: begin
               if (w_valid) begin
                  r_occupied       <= r_occupied | r_meta_sw;
                  r_owner[w_idx]   <= r_player;
                  r_cell_idx       <= w_idx;
                  r_draw_req       <= 1'b1;
                  r_draw_cnt       <= '0;
               end else begin
                  r_move_reject    <= 1'b1;
               end
            end
            ST_DRAW_ACK: begin
               r_draw_cnt <= w_cnt_next;
               if (drawing || w_timeout) begin
                  r_draw_req <= 1'b0;
               end
            end
            // A win outranks a full board: the last move may both fill and win.
            ST_ADVANCE: begin
               if (win) begin
                  r_gameover <= 1'b1;
                  r_winner   <= r_player;
                  r_tie      <= 1'b0;
               end else if (w_board_full) begin
                  r_gameover <= 1'b1;
                  r_tie      <= 1'b1;
               end else begin
                  r_player   <= w_player_next;
               end
            end
            ST_GAMEOVER: begin
               if (new_game) begin
                  r_occupied <= '0;
                  r_owner    <= '0;
                  r_player   <= '0;
                  r_gameover <= 1'b0;
                  r_tie      <= 1'b0;
                  r_winner   <= '0;
                  r_cell_idx <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign meta_sw     = r_meta_sw;
   assign cell_idx    = r_cell_idx;
   assign player      = r_player;
   assign occupied    = r_occupied;
   assign draw_req    = r_draw_req;
   assign move_reject = r_move_reject;
   assign gameover    = r_gameover;
   assign tie         = r_tie;
   assign winner      = r_winner;
   assign holding     = (r_state != ST_READ);
   assign dbg_state   = r_state;
   assign dbg_owner   = r_owner;

endmodule
